// File: rtl/foc_pkg.sv
// Shared types for the d/q PI scheduler: FSM state encoding and axis selection.
package foc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    PROP = 3'd2,
    INTG = 3'd3,
    SAT  = 3'd4,
    AW   = 3'd5,
    DONE = 3'd6
  } state_e;

  typedef enum logic {
    AXIS_D = 1'b0,
    AXIS_Q = 1'b1
  } axis_e;

  function automatic logic is_busy(input state_e s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/pi_shared_mult.sv
// Single signed multiplier time-shared between the proportional, integral and back-calculation products.
module pi_shared_mult #(
  parameter int A_W = 10,
  parameter int B_W = 24
) (
  input  logic signed [A_W-1:0]     a_i,
  input  logic signed [B_W-1:0]     b_i,
  output logic signed [A_W+B_W-1:0] p_o
);

  localparam int P_W = A_W + B_W;

  // Full-precision product; both operands sign-extended so the result never wraps
  always_comb begin
    p_o = P_W'(a_i) * P_W'(b_i);
  end

endmodule

// File: rtl/foc_pi_scheduler.sv
// Sequential d/q PI current controller: one shared multiplier, 11-cycle step,
// saturating integrators with optional back-calculation anti-windup.
module foc_pi_scheduler
  import foc_pkg::*;
#(
  parameter int W           = 10,
  parameter int F           = 9,
  parameter int ANTI_WINDUP = 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic signed [W-1:0] id_ref,
  input  logic signed [W-1:0] iq_ref,
  input  logic signed [W-1:0] id_meas,
  input  logic signed [W-1:0] iq_meas,
  input  logic signed [W-1:0] kp,
  input  logic signed [W-1:0] ki,
  input  logic signed [W-1:0] kaw,
  input  logic signed [W-1:0] u_max,
  input  logic                int_hold,
  input  logic                int_clr,
  output logic signed [W-1:0] vd,
  output logic signed [W-1:0] vq,
  output logic                valid,
  output logic                busy,
  output logic                overrun
);

  localparam int IW = W + F + 2;
  localparam int EW = W + 1;
  // u_raw magnitude is bounded by 2^(2W+1); one spare bit keeps u_sat - u_raw exact
  localparam int UW = 2 * W + 3;
  localparam int DW = UW + 1;
  localparam int BW = (DW > IW) ? DW : IW;
  localparam int PW = W + BW;
  localparam int SW = PW + 2;
  localparam logic signed [IW-1:0] IMAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] IMIN = {1'b1, {(IW-1){1'b0}}};

  function automatic logic signed [IW-1:0] sat_integ(input logic signed [SW-1:0] x);
    if (x > SW'(IMAX)) begin
      return IMAX;
    end else if (x < SW'(IMIN)) begin
      return IMIN;
    end else begin
      return IW'(x);
    end
  endfunction

  state_e state_q, state_d;
  axis_e  axis_q, axis_d;
  logic   ax_s, accept_s;

  logic signed [W-1:0]  ref_q [2];
  logic signed [W-1:0]  meas_q [2];
  logic signed [W-1:0]  kp_q, ki_q, kaw_q, umax_q;
  logic signed [EW-1:0] e_q;
  logic signed [PW-1:0] pp_q;
  logic signed [PW:0]   sum_q;
  logic signed [UW-1:0] u_raw_q, u_raw_s, umax_ext_s;
  logic signed [W-1:0]  u_sat_q, u_sat_s, res_d_q;
  logic signed [IW-1:0] integ_q [2];
  logic signed [IW-1:0] integ_d [2];
  logic signed [IW-1:0] integ_new_s;
  logic signed [SW-1:0] aw_s;
  logic signed [W-1:0]  mul_a_s;
  logic signed [BW-1:0] mul_b_s;
  logic signed [PW-1:0] mul_p_s;
  logic signed [W-1:0]  vd_q, vq_q;
  logic                 valid_q, busy_q, overrun_q;

  assign ax_s     = (axis_q == AXIS_Q);
  assign accept_s = start && ((state_q == IDLE) || (state_q == DONE));

  pi_shared_mult #(.A_W(W), .B_W(BW)) u_mult (
    .a_i (mul_a_s),
    .b_i (mul_b_s),
    .p_o (mul_p_s)
  );

  // FSM state and axis registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      axis_q  <= AXIS_D;
    end else begin
      state_q <= state_d;
      axis_q  <= axis_d;
    end
  end

  // Next-state: five datapath states per axis, d before q
  always_comb begin
    state_d = state_q;
    axis_d  = axis_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ERR;
          axis_d  = AXIS_D;
        end else begin
          state_d = IDLE;
        end
      end
      ERR:  state_d = PROP;
      PROP: state_d = INTG;
      INTG: state_d = SAT;
      SAT:  state_d = AW;
      AW: begin
        if (axis_q == AXIS_D) begin
          state_d = ERR;
          axis_d  = AXIS_Q;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        axis_d  = AXIS_D;
      end
    endcase
  end

  // Multiplier operand routing by state
  always_comb begin
    mul_a_s = '0;
    mul_b_s = '0;
    case (state_q)
      PROP: begin
        mul_a_s = kp_q;
        mul_b_s = BW'(e_q);
      end
      INTG: begin
        mul_a_s = ki_q;
        mul_b_s = BW'(integ_q[ax_s]);
      end
      AW: begin
        mul_a_s = kaw_q;
        mul_b_s = BW'(u_sat_q) - BW'(u_raw_q);
      end
      default: begin
        mul_a_s = '0;
        mul_b_s = '0;
      end
    endcase
  end

  // Output scaling and symmetric clamp; a non-positive limit forces zero
  always_comb begin
    u_raw_s    = UW'(sum_q >>> F);
    umax_ext_s = UW'(umax_q);
    if (umax_q[W-1] || (umax_q == '0)) begin
      u_sat_s = '0;
    end else if (u_raw_s > umax_ext_s) begin
      u_sat_s = umax_q;
    end else if (u_raw_s < -umax_ext_s) begin
      u_sat_s = -umax_q;
    end else begin
      u_sat_s = W'(u_raw_s);
    end
  end

  // Integrator update: clear beats the AW write, hold suppresses it
  always_comb begin
    if (ANTI_WINDUP != 0) begin
      aw_s = SW'(mul_p_s >>> F);
    end else begin
      aw_s = '0;
    end
    integ_new_s = sat_integ(SW'(integ_q[ax_s]) + SW'(e_q) + aw_s);
    integ_d[0]  = integ_q[0];
    integ_d[1]  = integ_q[1];
    if (int_clr) begin
      integ_d[0] = '0;
      integ_d[1] = '0;
    end else if ((state_q == AW) && !int_hold) begin
      integ_d[ax_s] = integ_new_s;
    end else begin
      integ_d[ax_s] = integ_q[ax_s];
    end
  end

  // Input snapshots and per-state datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ref_q[0]   <= '0;
      ref_q[1]   <= '0;
      meas_q[0]  <= '0;
      meas_q[1]  <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      kaw_q      <= '0;
      umax_q     <= '0;
      e_q        <= '0;
      pp_q       <= '0;
      sum_q      <= '0;
      u_raw_q    <= '0;
      u_sat_q    <= '0;
      res_d_q    <= '0;
      integ_q[0] <= '0;
      integ_q[1] <= '0;
    end else begin
      integ_q[0] <= integ_d[0];
      integ_q[1] <= integ_d[1];
      if (accept_s) begin
        ref_q[0]  <= id_ref;
        ref_q[1]  <= iq_ref;
        meas_q[0] <= id_meas;
        meas_q[1] <= iq_meas;
        kp_q      <= kp;
        ki_q      <= ki;
        kaw_q     <= kaw;
        umax_q    <= u_max;
      end
      case (state_q)
        ERR:  e_q   <= EW'(ref_q[ax_s]) - EW'(meas_q[ax_s]);
        PROP: pp_q  <= mul_p_s;
        INTG: sum_q <= (PW+1)'(pp_q) + (PW+1)'(mul_p_s);
        SAT: begin
          u_raw_q <= u_raw_s;
          u_sat_q <= u_sat_s;
          if (axis_q == AXIS_D) begin
            res_d_q <= u_sat_s;
          end
        end
        default: begin
          e_q <= e_q;
        end
      endcase
    end
  end

  // Registered status and outputs; vd/vq change only on entry to DONE
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vd_q      <= '0;
      vq_q      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= (state_d == DONE);
      busy_q    <= is_busy(state_d);
      overrun_q <= start && is_busy(state_q);
      if (state_d == DONE) begin
        vd_q <= res_d_q;
        vq_q <= u_sat_q;
      end
    end
  end

  assign vd      = vd_q;
  assign vq      = vq_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_foc_pi_scheduler.sv
// Scoreboard bench for foc_pi_scheduler: a longint reference model predicts each step,
// a monitor compares vd/vq and the valid cycle whenever valid pulses.
module tb_foc_pi_scheduler;

  localparam int W = 10;
  localparam int F = 9;

  logic clk = 1'b0;
  logic nrst, start, int_hold, int_clr;
  logic signed [W-1:0] id_ref, iq_ref, id_meas, iq_meas, kp, ki, kaw, u_max;
  logic signed [W-1:0] vd, vq;
  logic valid, busy, overrun;

  foc_pi_scheduler #(.W(W), .F(F), .ANTI_WINDUP(1)) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .id_ref(id_ref), .iq_ref(iq_ref), .id_meas(id_meas), .iq_meas(iq_meas),
    .kp(kp), .ki(ki), .kaw(kaw), .u_max(u_max),
    .int_hold(int_hold), .int_clr(int_clr),
    .vd(vd), .vq(vq), .valid(valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idr, iqr, idm, iqm, kp, ki, kaw, umax;
    bit hold;
  } stim_t;

  typedef struct {
    longint vd, vq;
    int     cyc;
  } exp_t;

  exp_t   exp_q[$];
  longint mi[2];
  longint last_vd = 0, last_vq = 0;
  int     n_checks = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int rs10();
    return int'($urandom_range(1023, 0)) - 512;
  endfunction

  function automatic longint clampl(input longint x, input longint lo, input longint hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic stim_t zero_stim();
    stim_t s;
    s = '{idr: 0, iqr: 0, idm: 0, iqm: 0, kp: 0, ki: 0, kaw: 0, umax: 0, hold: 1'b0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.idr = rs10(); s.iqr = rs10(); s.idm = rs10(); s.iqm = rs10();
    s.kp = rs10(); s.ki = rs10(); s.kaw = rs10(); s.umax = rs10();
    s.hold = ($urandom_range(3, 0) == 0);
    return s;
  endfunction

  // Reference step: one PI update per axis in plain arithmetic; clr_after_d models a clear at d-axis AW
  task automatic model_step(input stim_t s, input bit clr_after_d, output longint od, output longint oq);
    longint r[2], m[2], o[2];
    longint e, ur, us, awt, lim;
    r[0] = s.idr; r[1] = s.iqr; m[0] = s.idm; m[1] = s.iqm;
    lim = longint'(1) << (W + F + 1);
    for (int ax = 0; ax < 2; ax++) begin
      e   = r[ax] - m[ax];
      ur  = (s.kp * e + s.ki * mi[ax]) >>> F;
      us  = (s.umax <= 0) ? 0 : clampl(ur, -s.umax, s.umax);
      awt = (s.kaw * (us - ur)) >>> F;
      if (!s.hold) mi[ax] = clampl(mi[ax] + e + awt, -lim, lim - 1);
      if (ax == 0 && clr_after_d) begin
        mi[0] = 0;
        mi[1] = 0;
      end
      o[ax] = us;
    end
    od = o[0];
    oq = o[1];
  endtask

  task automatic drive(input stim_t s);
    id_ref = s.idr[W-1:0]; iq_ref = s.iqr[W-1:0];
    id_meas = s.idm[W-1:0]; iq_meas = s.iqm[W-1:0];
    kp = s.kp[W-1:0]; ki = s.ki[W-1:0]; kaw = s.kaw[W-1:0]; u_max = s.umax[W-1:0];
    int_hold = s.hold;
  endtask

  task automatic scramble();
    id_ref = W'($urandom); iq_ref = W'($urandom); id_meas = W'($urandom); iq_meas = W'($urandom);
    kp = W'($urandom); ki = W'($urandom); kaw = W'($urandom); u_max = W'($urandom);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start in the next cycle c; returns at cycle c+1 with inputs scrambled
  task automatic issue(input stim_t s, input bit push, input bit clr_after_d);
    longint od, oq;
    exp_t x;
    @(posedge clk);
    #1;
    drive(s);
    start = 1'b1;
    model_step(s, clr_after_d, od, oq);
    if (push) begin
      x.vd = od; x.vq = oq; x.cyc = cyc + 11;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
  endtask

  task automatic run_step(input stim_t s);
    issue(s, 1'b1, 1'b0);
    wait_cycles(10);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    int_clr = 1'b1;
    mi[0] = 0;
    mi[1] = 0;
    @(posedge clk);
    #1;
    int_clr = 1'b0;
  endtask

  // Monitor: pop on every valid, otherwise outputs must hold their last value
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        last_vd = 0;
        last_vq = 0;
      end else if (valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid=1 at cycle %0d, expected no pending step", cyc);
        end else begin
          x = exp_q.pop_front();
          check("vd", vd, x.vd);
          check("vq", vq, x.vq);
          check("valid_cycle", cyc, x.cyc);
          last_vd = x.vd;
          last_vq = x.vq;
        end
      end else begin
        check("vd_hold", vd, last_vd);
        check("vq_hold", vq, last_vq);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    nrst = 1'b0; start = 1'b0; int_hold = 1'b0; int_clr = 1'b0;
    id_ref = '0; iq_ref = '0; id_meas = '0; iq_meas = '0;
    kp = '0; ki = '0; kaw = '0; u_max = '0;
    mi[0] = 0; mi[1] = 0;
    wait_cycles(3);
    check("rst_vd", vd, 0);
    check("rst_vq", vq, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    nrst = 1'b1;

    // Proportional step with busy profile
    s = zero_stim(); s.kp = 256; s.umax = 511; s.idr = 100;
    check("idle_busy", busy, 0);
    issue(s, 1'b1, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("busy_profile", busy, (k <= 10) ? 1 : 0);
    end
    check("prop_vd", vd, 50);
    check("prop_valid", valid, 1);

    // Clamp and zero limit
    s = zero_stim(); s.kp = 511; s.idr = 400; s.umax = 200;
    run_step(s);
    check("clamp_vd", vd, 200);
    s.umax = 0;
    run_step(s);
    check("zero_limit_vd", vd, 0);

    // Integrator from a cleared state
    pulse_clr();
    s = zero_stim(); s.ki = 256; s.iqr = 10; s.umax = 511;
    run_step(s);
    check("integ_first_vq", vq, 0);
    run_step(s);
    check("integ_second_vq", vq, 5);

    // Anti-windup: integrator lands at 300, observed through ki
    pulse_clr();
    s = zero_stim(); s.kp = 511; s.kaw = 256; s.idr = 400; s.umax = 200;
    run_step(s);
    check("aw_vd", vd, 200);
    s = zero_stim(); s.ki = 256; s.umax = 511;
    run_step(s);
    check("aw_integ_view", vd, 150);

    // int_clr during d-axis AW beats the write
    s = zero_stim(); s.ki = 256; s.idr = 40; s.iqr = -30; s.umax = 511;
    issue(s, 1'b1, 1'b1);
    wait_cycles(4);
    int_clr = 1'b1;
    wait_cycles(1);
    int_clr = 1'b0;
    wait_cycles(5);
    s = zero_stim(); s.ki = 256; s.umax = 511;
    run_step(s);
    check("clr_in_aw_vd", vd, 0);

    // Overrun in cycle 3, then back-to-back start in DONE
    s = rand_stim(); s.hold = 1'b0;
    issue(s, 1'b1, 1'b0);
    wait_cycles(2);
    start = 1'b1;
    scramble();
    @(negedge clk);
    check("overrun_c3", overrun, 0);
    wait_cycles(1);
    start = 1'b0;
    @(negedge clk);
    check("overrun_c4", overrun, 1);
    wait_cycles(1);
    @(negedge clk);
    check("overrun_c5", overrun, 0);
    wait_cycles(5);
    s = rand_stim();
    issue(s, 1'b1, 1'b0);
    wait_cycles(10);

    // Drive the integrator into positive saturation, then read its sign through ki=1
    pulse_clr();
    for (int i = 0; i < 14; i++) begin
      s = zero_stim(); s.kp = 511; s.ki = 511; s.kaw = -512;
      s.idr = 511; s.idm = -512; s.umax = 1;
      issue(s, 1'b1, 1'b0);
      wait_cycles(9);
    end
    wait_cycles(2);
    s = zero_stim(); s.ki = 1; s.umax = 511;
    run_step(s);
    check("integ_sat_view", vd, 511);

    // Reset in cycle 6 aborts the step
    s = rand_stim();
    issue(s, 1'b0, 1'b0);
    wait_cycles(5);
    nrst = 1'b0;
    #1;
    check("midrst_vd", vd, 0);
    check("midrst_vq", vq, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    mi[0] = 0;
    mi[1] = 0;
    wait_cycles(2);
    nrst = 1'b1;
    s = rand_stim();
    run_step(s);

    // Randomized steps, mix of back-to-back and idle gaps
    for (int i = 0; i < 30; i++) begin
      s = rand_stim();
      issue(s, 1'b1, 1'b0);
      wait_cycles(9 + int'($urandom_range(2, 0)));
    end

    wait_cycles(15);
    check("pending_expectations", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
